// File: rtl/mix_columns_engine.sv
// mix_columns_engine: AES MixColumns/InvMixColumns over a valid/ready handshake,
// transforming LANES 32-bit columns per cycle with xtime arithmetic.
module mix_columns_engine #(
    parameter int LANES = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_mode,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);
    if (LANES != 1 && LANES != 2 && LANES != 4) begin : g_bad_lanes
        $error("mix_columns_engine: LANES must be 1, 2 or 4");
    end

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t       state, state_nxt;
    logic [127:0] work, work_nxt;
    logic         mode;
    logic [1:0]   col, c;
    logic         last;

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Multiply by a 4-bit constant as an XOR of the 1/2/4/8 multiples.
    function automatic logic [7:0] gm(input logic [7:0] b, input logic [3:0] k);
        logic [7:0] m2, m4, m8;
        m2 = xt(b);
        m4 = xt(m2);
        m8 = xt(m4);
        return (k[0] ? b : 8'h00) ^ (k[1] ? m2 : 8'h00) ^ (k[2] ? m4 : 8'h00) ^ (k[3] ? m8 : 8'h00);
    endfunction

    function automatic logic [31:0] mix(input logic [31:0] x, input logic inv);
        logic [7:0]  a [4];
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) a[i] = x[31-8*i -: 8];
        for (int i = 0; i < 4; i++)
            r[31-8*i -: 8] = inv ? gm(a[i], 4'he) ^ gm(a[(i+1)%4], 4'hb) ^ gm(a[(i+2)%4], 4'hd) ^ gm(a[(i+3)%4], 4'h9)
                                 : gm(a[i], 4'h2) ^ gm(a[(i+1)%4], 4'h3) ^ a[(i+2)%4] ^ a[(i+3)%4];
        return r;
    endfunction

    always_comb begin
        last      = (3'(col) + 3'(LANES)) == 3'd4;
        state_nxt = (state == IDLE && in_valid)  ? BUSY :
                    (state == BUSY && last)      ? DONE :
                    (state == DONE && out_ready) ? IDLE : state;
        work_nxt  = work;
        c         = col;
        for (int l = 0; l < LANES; l++) begin
            c = col + 2'(l);
            work_nxt[127-32*int'(c) -: 32] = mix(work[127-32*int'(c) -: 32], mode);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            work     <= '0;
            mode     <= 1'b0;
            col      <= '0;
            out_data <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && in_valid) begin
                work <= in_data;
                mode <= in_mode;
                col  <= '0;
            end
            if (state == BUSY) begin
                work <= work_nxt;
                col  <= col + 2'(LANES);
                if (last) out_data <= work_nxt;
            end
        end
    end

    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;
    assign busy      = state != IDLE;
endmodule

// File: tb/tb_mix_columns_engine.sv
// tb_mix_columns_engine: scoreboard bench for LANES=1/2/4 instances against a
// generic GF(2^8) matrix-multiply reference model.
module tb_mix_columns_engine;
    logic         clk = 0;
    logic         rst_n = 0;
    logic         in_valid [3];
    logic         in_ready [3];
    logic         in_mode [3];
    logic [127:0] in_data [3];
    logic         out_valid [3];
    logic         out_ready [3];
    logic [127:0] out_data [3];
    logic         busy [3];
    logic         man_ready [3];
    logic         rnd_bits [3];
    logic         rnd_on = 0;
    int           checks = 0, errors = 0, cyc = 0;
    int           sent [3], done [3];
    logic [127:0] q0 [$], q1 [$], q2 [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    mix_columns_engine #(.LANES(1)) u0 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_mode(in_mode[0]), .in_data(in_data[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_data(out_data[0]), .busy(busy[0]));
    mix_columns_engine #(.LANES(2)) u1 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_mode(in_mode[1]), .in_data(in_data[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_data(out_data[1]), .busy(busy[1]));
    mix_columns_engine #(.LANES(4)) u2 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .in_mode(in_mode[2]), .in_data(in_data[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
        .out_data(out_data[2]), .busy(busy[2]));

    always_comb for (int i = 0; i < 3; i++) out_ready[i] = rnd_on ? rnd_bits[i] : man_ready[i];

    always @(posedge clk) begin
        #1;
        for (int i = 0; i < 3; i++) rnd_bits[i] = $urandom_range(0, 3) != 0;
    end

    function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
        logic [7:0] p;
        p = '0;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p ^= a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Each output byte is a row of the circulant matrix times the column vector.
    function automatic logic [127:0] ref_mix(logic [127:0] d, logic inv);
        logic [7:0]   k [4];
        logic [7:0]   s;
        logic [127:0] r;
        if (inv) begin k[0] = 8'h0e; k[1] = 8'h0b; k[2] = 8'h0d; k[3] = 8'h09; end
        else     begin k[0] = 8'h02; k[1] = 8'h03; k[2] = 8'h01; k[3] = 8'h01; end
        r = '0;
        for (int c = 0; c < 4; c++)
            for (int i = 0; i < 4; i++) begin
                s = '0;
                for (int j = 0; j < 4; j++) s ^= gmul(d[127-32*c-8*((i+j)%4) -: 8], k[j]);
                r[127-32*c-8*i -: 8] = s;
            end
        return r;
    endfunction

    function automatic void push(int i, logic [127:0] v);
        case (i)
            0: q0.push_back(v);
            1: q1.push_back(v);
            default: q2.push_back(v);
        endcase
    endfunction

    function automatic logic [127:0] pop(int i);
        case (i)
            0: return q0.pop_front();
            1: return q1.pop_front();
            default: return q2.pop_front();
        endcase
    endfunction

    function automatic int qsize(int i);
        return i == 0 ? q0.size() : i == 1 ? q1.size() : q2.size();
    endfunction

    task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk)
        for (int i = 0; i < 3; i++)
            if (rst_n && out_valid[i] && out_ready[i]) begin
                if (qsize(i) == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out%0d got %h expected no output", i, out_data[i]);
                end else chk($sformatf("sb_out%0d", i), out_data[i], pop(i));
                done[i]++;
            end

    task automatic send(int i, logic [127:0] d, logic m, output int acc);
        @(posedge clk) #1;
        in_valid[i] = 1;
        in_data[i]  = d;
        in_mode[i]  = m;
        acc = -1;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (in_ready[i]) begin acc = cyc; break; end
        end
        if (acc < 0) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout%0d got no in_ready expected in_ready", i);
        end else begin
            push(i, ref_mix(d, m));
            sent[i]++;
        end
        @(posedge clk) #1;
        in_valid[i] = 0;
    endtask

    task automatic wait_out(int i, output int c);
        c = -1;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (out_valid[i]) begin c = cyc; break; end
        end
        if (c < 0) begin
            checks++;
            errors++;
            $display("FAIL out_timeout%0d got no out_valid expected out_valid", i);
        end
    endtask

    task automatic run_rand(int i);
        int acc;
        for (int n = 0; n < 1000; n++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            send(i, {$urandom, $urandom, $urandom, $urandom}, 1'($urandom_range(0, 1)), acc);
        end
    endtask

    initial begin
        int acc, c, d0;
        logic [127:0] hold, fwd;
        for (int i = 0; i < 3; i++) begin
            in_valid[i] = 0; in_mode[i] = 0; in_data[i] = '0;
            man_ready[i] = 1; sent[i] = 0; done[i] = 0;
        end
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst_out_valid%0d", i), 128'(out_valid[i]), 128'd0);
            chk($sformatf("rst_busy%0d", i), 128'(busy[i]), 128'd0);
            chk($sformatf("rst_out_data%0d", i), out_data[i], 128'd0);
        end
        @(posedge clk) #1 rst_n = 1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) chk($sformatf("rst_in_ready%0d", i), 128'(in_ready[i]), 128'd1);

        send(0, 128'hdb135345_f20a225c_01010101_c6c6c6c6, 0, acc);
        wait_out(0, c);
        chk("fwd_l1_data", out_data[0], 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6);
        chk("fwd_l1_latency", 128'(c - acc), 128'd5);

        send(2, 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, 1, acc);
        wait_out(2, c);
        chk("inv_l4_data", out_data[2], 128'hdb135345_f20a225c_01010101_c6c6c6c6);
        chk("inv_l4_latency", 128'(c - acc), 128'd2);

        send(1, 128'hd4d4d4d5_2d26314c_00000000_ffffffff, 0, acc);
        wait_out(1, c);
        fwd = out_data[1];
        chk("rt_l2_fwd", fwd, 128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff);
        chk("rt_l2_latency", 128'(c - acc), 128'd3);
        send(1, fwd, 1, acc);
        wait_out(1, c);
        chk("rt_l2_inv", out_data[1], 128'hd4d4d4d5_2d26314c_00000000_ffffffff);

        man_ready[0] = 0;
        hold = 128'h00112233_44556677_8899aabb_ccddeeff;
        send(0, hold, 0, acc);
        d0 = done[0];
        for (int n = 0; n < 30 && !out_valid[0]; n++) begin
            @(posedge clk) #1;
            in_valid[0] = 1'($urandom_range(0, 1));
            in_mode[0]  = ~in_mode[0];
            in_data[0]  = {$urandom, $urandom, $urandom, $urandom};
            @(negedge clk);
            chk("bp_busy_in_ready", 128'(in_ready[0]), 128'd0);
        end
        chk("bp_reached_done", 128'(out_valid[0]), 128'd1);
        chk("bp_data", out_data[0], ref_mix(hold, 0));
        hold = out_data[0];
        for (int n = 0; n < 10; n++) begin
            @(posedge clk) #1;
            in_valid[0] = 1'($urandom_range(0, 1));
            in_mode[0]  = ~in_mode[0];
            in_data[0]  = {$urandom, $urandom, $urandom, $urandom};
            @(negedge clk);
            chk("bp_hold_valid", 128'(out_valid[0]), 128'd1);
            chk("bp_hold_data", out_data[0], hold);
            chk("bp_hold_in_ready", 128'(in_ready[0]), 128'd0);
        end
        @(posedge clk) #1;
        in_valid[0] = 0;
        man_ready[0] = 1;
        repeat (4) @(negedge clk);
        chk("bp_one_txn", 128'(done[0] - d0), 128'd1);

        send(0, 128'hdb135345_f20a225c_01010101_c6c6c6c6, 1, acc);
        @(posedge clk) #1 rst_n = 0;
        #1;
        chk("mid_rst_out_valid", 128'(out_valid[0]), 128'd0);
        chk("mid_rst_out_data", out_data[0], 128'd0);
        chk("mid_rst_busy", 128'(busy[0]), 128'd0);
        q0.delete();
        sent[0] = done[0];
        @(posedge clk) #1 rst_n = 1;
        @(negedge clk);
        chk("mid_rst_in_ready", 128'(in_ready[0]), 128'd1);
        send(0, 128'hd4d4d4d5_2d26314c_00000000_ffffffff, 0, acc);
        wait_out(0, c);
        chk("post_rst_data", out_data[0], 128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff);

        rnd_on = 1;
        fork
            run_rand(0);
            run_rand(1);
            run_rand(2);
        join
        for (int n = 0; n < 200 && (q0.size() + q1.size() + q2.size()) != 0; n++) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rand_count%0d", i), 128'(done[i]), 128'(sent[i]));
            chk($sformatf("rand_drain%0d", i), 128'(qsize(i)), 128'd0);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mix_columns_engine.md
# mix_columns_engine

Parametrised, sequential AES MixColumns / InvMixColumns engine for the AES-256 datapath. It accepts a 128-bit state over a valid/ready handshake and a per-transaction mode bit (forward for encryption, inverse for decryption). It processes `LANES` 32-bit columns per cycle using GF(2^8) xtime arithmetic rather than lookup tables, and returns the result over a valid/ready output handshake. One instance serves both the encryption and decryption round pipelines.

## Interface
- `LANES`, default 1: columns processed per cycle. Legal values are 1, 2 or 4; any other value is an elaboration error.
- `clk`  input  1: sole clock, rising edge.
- `rst_n`  input  1: asynchronous, active-low reset.
- `in_valid`  input  1: input transaction valid.
- `in_ready`  output  1: engine can accept a transaction.
- `in_mode`  input  1: 0 = MixColumns (02 03 01 01), 1 = InvMixColumns (0e 0b 0d 09).
- `in_data`  input  128: state. Column c is `[127-32c -: 32]`; within a column, bits [31:24] are row 0.
- `out_valid`  output  1: result valid.
- `out_ready`  input  1: downstream accepts the result.
- `out_data`  output  128: transformed state, same layout as `in_data`.
- `busy`  output  1: high in BUSY and DONE.

## Operation
- State machine: IDLE, BUSY, DONE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid && in_ready`, capture `in_data` into the work register and `in_mode` into the mode register, clear column counter `col`, and go to BUSY.
- BUSY:
  - Each cycle, transform columns `col .. col+LANES-1` in place.
  - Then `col += LANES`.
  - When the last group is done (`col+LANES == 4`), load `out_data` from the updated work register and go to DONE.
  - `col` is 2 bits wide and wraps to 0 on its final increment.
- DONE:
  - `out_valid`=1, and `out_data` is held stable until `out_valid && out_ready`.
  - On that handshake, go to IDLE.
- Column math, with row bytes a0..a3 and all additions as XOR:
  - Forward: r_i = 2·a_i ^ 3·a_{i+1} ^ a_{i+2} ^ a_{i+3} (indices mod 4).
  - Inverse: r_i = e·a_i ^ b·a_{i+1} ^ d·a_{i+2} ^ 9·a_{i+3}.
  - Multiply by 2 (xtime): `{a[6:0],1'b0} ^ (a[7] ? 8'h1b : 8'h00)`.
  - Multiply by 4 and 8 are repeated xtime. The 9, b, d, e multiples are XOR combinations of 1/2/4/8 multiples.
  - All arithmetic is 8-bit with no carries.
- The mode register is fixed for the whole transaction. Changes on `in_mode` while `busy` are ignored.
- `in_valid` while not in IDLE is ignored. Nothing is queued, and `in_ready`=0.
- No accept occurs in the same cycle as an output handshake. `in_ready` rises the cycle after DONE exits.

## Timing
- Reset (asynchronous, on `rst_n`=0, applies in any state including mid-BUSY): state=IDLE, `col`=0, `in_ready`=1 after release, `out_valid`=0, `out_data`=128'h0, `busy`=0, work and mode registers=0. The in-flight transaction is discarded.
- Let N = 4/LANES. If the accept edge is at cycle T, the engine is BUSY for cycles T+1..T+N and `out_valid` rises at cycle T+N+1.
- Accept-to-`out_valid` latency is therefore N+1 cycles: 5 for LANES=1, 3 for LANES=2, 2 for LANES=4.
- Back-to-back throughput with `out_ready` held high is one transaction per N+2 cycles.
- When `out_ready`=0, DONE persists indefinitely with `out_data` unchanged.
- `in_ready`, `out_valid` and `busy` are registered state decodes, with no combinational path from `in_valid` or `out_ready`.

## Test plan
- Forward, LANES=1:
  - Stimulus: `in_data`=db135345_f20a225c_01010101_c6c6c6c6, mode 0.
  - Required: `out_data`=8e4da1bc_9fdc589d_01010101_c6c6c6c6, with `out_valid` exactly 5 cycles after accept.
- Inverse, LANES=4:
  - Stimulus: `in_data`=8e4da1bc_9fdc589d_01010101_c6c6c6c6, mode 1.
  - Required: `out_data`=db135345_f20a225c_01010101_c6c6c6c6, with latency 2.
- Round trip, LANES=2:
  - Stimulus: d4d4d4d5_2d26314c_00000000_ffffffff, forward, then feed the output back with inverse.
  - Required: the forward result is d5d5d7d6_4d7ebdf8_00000000_ffffffff, and the inverse result returns the original input.
- Backpressure and mode isolation:
  - Stimulus: hold `out_ready`=0 for 10 cycles in DONE; toggle `in_mode`, `in_valid` and `in_data` during BUSY and DONE.
  - Required: `out_data` is stable and correct, `in_ready`=0 throughout, and exactly one transaction completes.
- Reset mid-operation:
  - Stimulus: assert `rst_n`=0 during the 2nd BUSY cycle with LANES=1.
  - Required: `out_valid`=0, `out_data`=0 and `busy`=0 immediately; `in_ready`=1 after release; the next transaction gives the correct result.
- Random regression:
  - Stimulus: 1000 random states and modes for each LANES value, with random `in_valid`/`out_ready` gaps.
  - Required: results match the reference model, and no transaction is lost or duplicated.
